ps2_host_tx: RTL and testbench

- Host-to-device PS/2 transmitter. It is the counterpart of the receive-only mouse path.
- Sends one command byte to the mouse, for example 0xF4 "enable data reporting" or 0xFF "reset".
- Drives the open-drain ps2_clk/ps2_data lines through output-enable signals. When it is idle, the receiver owns the bus.
- The top level muxes the lines as: line = oe ? 1'b0 : 'z.

---
 rtl/ps2_host_tx.sv | 179 +++++++++++++++++
 tb/tb_ps2_host_tx.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, issues a request-to-send,
// then shifts one command byte out on device-generated clock falls and samples the ack bit.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int TIMEOUT_CYCLES = 900000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk60MHz,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout_err
);
    localparam int InhW = $clog2(INHIBIT_CYCLES + 1);
    localparam int ToW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [InhW-1:0] InhLast = InhW'(INHIBIT_CYCLES - 1);
    localparam logic [ToW-1:0]  ToLast  = ToW'(TIMEOUT_CYCLES - 1);
    localparam logic [ToW-1:0]  ToMax   = ToW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE, INHIBIT, REQ, SHIFT, STOP, ACK, WAIT_IDLE
    } state_t;

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] clkSync_q;
    logic [SYNC_STAGES-1:0] dataSync_q;
    logic                   clkPrev_q;
    logic                   fall_q;
    logic [8:0]             shreg_q;
    logic [8:0]             shreg_d;
    logic [3:0]             bitCnt_q;
    logic [InhW-1:0]        inhCnt_q;
    logic [ToW-1:0]         toCnt_q;
    logic [ToW-1:0]         toCnt_d;
    logic                   ackOk_q;
    logic                   clkOe_q;
    logic                   dataOe_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   ackErr_q;
    logic                   timeoutErr_q;
    logic                   clkS;
    logic                   dataS;

    assign clkS  = clkSync_q[SYNC_STAGES-1];
    assign dataS = dataSync_q[SYNC_STAGES-1];

    // Lines idle high, so synchronisers reset to 1 to avoid a phantom fall after reset.
    always_ff @(posedge clk60MHz or negedge rst) begin
        if (!rst) begin
            clkSync_q  <= '1;
            dataSync_q <= '1;
            clkPrev_q  <= 1'b1;
            fall_q     <= 1'b0;
        end else begin
            clkSync_q  <= SYNC_STAGES'({clkSync_q, ps2_clk_i});
            dataSync_q <= SYNC_STAGES'({dataSync_q, ps2_data_i});
            clkPrev_q  <= clkS;
            fall_q     <= clkPrev_q & ~clkS;
        end
    end

    always_comb begin
        toCnt_d = (toCnt_q == ToMax) ? toCnt_q : toCnt_q + ToW'(1);
        shreg_d = {1'b0, shreg_q[8:1]};
    end

    always_ff @(posedge clk60MHz or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            bitCnt_q     <= '0;
            inhCnt_q     <= '0;
            toCnt_q      <= '0;
            ackOk_q      <= 1'b0;
            clkOe_q      <= 1'b0;
            dataOe_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ackErr_q     <= 1'b0;
            timeoutErr_q <= 1'b0;
        end else begin
            done_q       <= 1'b0;
            ackErr_q     <= 1'b0;
            timeoutErr_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (tx_start) begin
                        shreg_q  <= {~^tx_data, tx_data};
                        bitCnt_q <= '0;
                        inhCnt_q <= '0;
                        busy_q   <= 1'b1;
                        clkOe_q  <= 1'b1;
                        dataOe_q <= 1'b0;
                        state_q  <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (inhCnt_q == InhLast) begin
                        dataOe_q <= 1'b1;
                        state_q  <= REQ;
                    end else begin
                        inhCnt_q <= inhCnt_q + InhW'(1);
                    end
                end
                REQ: begin
                    clkOe_q <= 1'b0;
                    toCnt_q <= '0;
                    state_q <= SHIFT;
                end
                SHIFT, STOP, ACK, WAIT_IDLE: begin
                    // Expiry is checked first so it wins over a coincident clock fall.
                    if (toCnt_q == ToLast) begin
                        clkOe_q      <= 1'b0;
                        dataOe_q     <= 1'b0;
                        busy_q       <= 1'b0;
                        timeoutErr_q <= 1'b1;
                        state_q      <= IDLE;
                    end else begin
                        toCnt_q <= toCnt_d;
                        case (state_q)
                            SHIFT: begin
                                if (fall_q) begin
                                    dataOe_q <= ~shreg_q[0];
                                    shreg_q  <= shreg_d;
                                    bitCnt_q <= bitCnt_q + 4'd1;
                                    if (bitCnt_q == 4'd8) begin
                                        state_q <= STOP;
                                    end
                                end
                            end
                            STOP: begin
                                if (fall_q) begin
                                    dataOe_q <= 1'b0;
                                    state_q  <= ACK;
                                end
                            end
                            ACK: begin
                                if (fall_q) begin
                                    ackOk_q <= ~dataS;
                                    state_q <= WAIT_IDLE;
                                end
                            end
                            default: begin
                                if (clkS && dataS) begin
                                    done_q   <= 1'b1;
                                    ackErr_q <= ~ackOk_q;
                                    busy_q   <= 1'b0;
                                    state_q  <= IDLE;
                                end
                            end
                        endcase
                    end
                end
                default: begin
                    clkOe_q  <= 1'b0;
                    dataOe_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign ps2_clk_oe  = clkOe_q;
    assign ps2_data_oe = dataOe_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign ack_err     = ackErr_q;
    assign timeout_err = timeoutErr_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks bytes out of the host while a
// scoreboard compares every done/timeout response against frames built from the byte.
module tb_ps2_host_tx;
    localparam int INH        = 50;
    localparam int TO         = 4000;
    localparam int HALF       = 20;
    localparam int IDLE_LIMIT = 3 * TO;
    localparam int MODE_ACK    = 0;
    localparam int MODE_NOACK  = 1;
    localparam int MODE_SILENT = 2;

    typedef struct packed {
        logic        isTimeout;
        logic        ackErr;
        logic [10:0] frame;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] txData;
    logic       txStart;
    logic       clkOe, dataOe, busy, done, ackErr, timeoutErr;
    logic       devClkLow  = 1'b0;
    logic       devDataLow = 1'b0;
    logic       clkLine, dataLine;
    logic       bfmBusy = 1'b0;
    int         bfmBits = 0;
    int         deviceMode = MODE_ACK;
    int         nChecks = 0;
    int         nFails = 0;
    int         cyc = 0;
    int         oeRun = 0;
    int         fallCyc = 0;
    logic       doneLast = 1'b0;
    exp_t       expQ[$];
    logic [10:0] rxQ[$];
    exp_t       monE;

    assign clkLine  = ~(clkOe | devClkLow);
    assign dataLine = ~(dataOe | devDataLow);

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TO),
        .SYNC_STAGES(2)
    ) dut (
        .clk60MHz   (clk),
        .rst        (rst),
        .tx_data    (txData),
        .tx_start   (txStart),
        .ps2_clk_i  (clkLine),
        .ps2_data_i (dataLine),
        .ps2_clk_oe (clkOe),
        .ps2_data_oe(dataOe),
        .busy       (busy),
        .done       (done),
        .ack_err    (ackErr),
        .timeout_err(timeoutErr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #(60000 * 10);
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Frame as the device sees it on rising edges: start, data LSB first, odd parity, stop.
    function automatic logic [10:0] buildFrame(input logic [7:0] d);
        logic [10:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = ((d >> i) & 8'd1) != 8'd0;
        f[9]  = ($countones(d) % 2) == 0;
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic waitIdle();
        for (int n = 0; n < IDLE_LIMIT && (busy || bfmBusy); n++) @(posedge clk);
        checkOutput("idle_reached", int'(busy || bfmBusy), 0);
        repeat (3) @(posedge clk);
    endtask

    task automatic waitBfmBits(input int bits);
        for (int n = 0; n < IDLE_LIMIT && !(bfmBusy && bfmBits >= bits); n++) @(posedge clk);
        checkOutput("bfm_progress", int'(bfmBusy && bfmBits >= bits), 1);
    endtask

    task automatic applyStimulus(input logic [7:0] d, input int mode);
        exp_t e;
        waitIdle();
        deviceMode  = mode;
        e.isTimeout = (mode == MODE_SILENT);
        e.ackErr    = (mode == MODE_NOACK);
        e.frame     = buildFrame(d);
        expQ.push_back(e);
        @(posedge clk); #1;
        txData  = d;
        txStart = 1'b1;
        @(negedge clk);
        checkOutput("clk_oe_before_accept", clkOe, 0);
        @(posedge clk); #1;
        txStart = 1'b0;
        @(negedge clk);
        checkOutput("clk_oe_latency", clkOe, 1);
        checkOutput("busy_after_accept", busy, 1);
    endtask

    // Device model: generates 11 clocks after a request, samples data on rising edges.
    initial begin : deviceBfm
        logic [10:0] rx;
        forever begin
            @(negedge clkOe);
            if (dataOe && rst && deviceMode != MODE_SILENT) begin
                bfmBusy = 1'b1;
                bfmBits = 0;
                repeat (HALF) @(posedge clk); #1;
                rx[0]   = dataLine;
                bfmBits = 1;
                for (int i = 1; i <= 10; i++) begin
                    devClkLow = 1'b1;
                    repeat (HALF) @(posedge clk); #1;
                    rx[i]     = dataLine;
                    devClkLow = 1'b0;
                    bfmBits   = i + 1;
                    repeat (HALF) @(posedge clk); #1;
                end
                rxQ.push_back(rx);
                if (deviceMode == MODE_ACK) devDataLow = 1'b1;
                repeat (2) @(posedge clk); #1;
                devClkLow = 1'b1;
                repeat (HALF) @(posedge clk); #1;
                devClkLow = 1'b0;
                repeat (4) @(posedge clk); #1;
                devDataLow = 1'b0;
                repeat (4) @(posedge clk); #1;
                bfmBusy = 1'b0;
            end
        end
    end

    // Monitor: clock-low length, one-cycle pulses, and scoreboard pops on each response.
    always @(negedge clk) begin
        if (!rst) begin
            oeRun    = 0;
            doneLast = 1'b0;
        end else begin
            if (clkOe) begin
                oeRun++;
            end else if (oeRun != 0) begin
                checkOutput("clk_low_len", oeRun, INH + 1);
                oeRun   = 0;
                fallCyc = cyc;
            end
            if (doneLast) checkOutput("done_width", done, 0);
            doneLast = done;
            if (done || timeoutErr) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_response", 1, 0);
                end else begin
                    monE = expQ.pop_front();
                    checkOutput("resp_timeout", timeoutErr, monE.isTimeout);
                    checkOutput("resp_done", done, !monE.isTimeout);
                    checkOutput("busy_at_end", busy, 0);
                    checkOutput("ack_err", ackErr, monE.isTimeout ? 0 : monE.ackErr);
                    if (monE.isTimeout) begin
                        checkOutput("timeout_latency", cyc - fallCyc, TO);
                        checkOutput("clk_oe_at_timeout", clkOe, 0);
                        checkOutput("data_oe_at_timeout", dataOe, 0);
                    end else if (rxQ.size() == 0) begin
                        checkOutput("frame_missing", 1, 0);
                    end else begin
                        checkOutput("frame", rxQ.pop_front(), monE.frame);
                    end
                end
            end
        end
    end

    initial begin
        rst     = 1'b0;
        txStart = 1'b0;
        txData  = 8'h00;
        repeat (3) @(posedge clk); #1;
        checkOutput("rst_clk_oe", clkOe, 0);
        checkOutput("rst_data_oe", dataOe, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_ack_err", ackErr, 0);
        checkOutput("rst_timeout_err", timeoutErr, 0);
        rst = 1'b1;

        applyStimulus(8'hF4, MODE_ACK);
        applyStimulus(8'h00, MODE_ACK);
        applyStimulus(8'hFF, MODE_ACK);
        applyStimulus(8'h01, MODE_ACK);
        applyStimulus(8'hA5, MODE_NOACK);
        applyStimulus(8'hFF, MODE_SILENT);

        applyStimulus(8'h5A, MODE_ACK);
        waitBfmBits(3);
        @(posedge clk); #1;
        txData  = 8'hAA;
        txStart = 1'b1;
        @(posedge clk); #1;
        txStart = 1'b0;
        @(negedge clk);
        checkOutput("busy_ignores_start", busy, 1);
        applyStimulus(8'hAA, MODE_ACK);

        applyStimulus(8'h00, MODE_ACK);
        waitBfmBits(5);
        repeat (2) @(posedge clk);
        @(posedge clk); #2;
        checkOutput("pre_reset_data_oe", dataOe, 1);
        rst = 1'b0;
        #1;
        checkOutput("mid_rst_clk_oe", clkOe, 0);
        checkOutput("mid_rst_data_oe", dataOe, 0);
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_done", done, 0);
        checkOutput("mid_rst_ack_err", ackErr, 0);
        checkOutput("mid_rst_timeout_err", timeoutErr, 0);
        expQ.delete();
        for (int n = 0; n < IDLE_LIMIT && bfmBusy; n++) @(posedge clk);
        rxQ.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        applyStimulus(8'h3C, MODE_ACK);

        for (int k = 0; k < 8; k++) begin
            applyStimulus(8'($urandom_range(0, 255)),
                          ($urandom_range(0, 3) == 0) ? MODE_NOACK : MODE_ACK);
        end

        waitIdle();
        for (int n = 0; n < 100 && expQ.size() != 0; n++) @(posedge clk);
        checkOutput("pending_responses", expQ.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
